// File: rtl/alu_ctrl_mc.sv
// Registered ALU control for the ID/EX boundary: decodes ALUOp/funct and sequences multi-cycle MULT/DIV.
// Define ALU_CTRL_DIV_EN to decode DIV (funct 011010) as a DIV_LAT-cycle op; otherwise it is flagged illegal.
module alu_ctrl_mc #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [5:0]        funct_i,
  input  logic [2:0]        ALUOp_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              illegal_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_MULTI = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       illegal;
  } dec_t;

  localparam logic [3:0] CODE_ADD = 4'b0010;
  localparam logic [3:0] CODE_SUB = 4'b0110;
  localparam logic [3:0] CODE_AND = 4'b0000;
  localparam logic [3:0] CODE_OR  = 4'b0001;
  localparam logic [3:0] CODE_SLT = 4'b0111;
  localparam logic [3:0] CODE_MUL = 4'b1000;
  localparam logic [3:0] CODE_DIV = 4'b1001;

  // Counter preload is L-1: number of stall cycles before the final EX cycle.
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic       illegal_q, illegal_d;
  dec_t       dec;
  logic       accept;

  function automatic dec_t decode(input logic [2:0] op, input logic [5:0] funct);
    dec_t d;
    d.code    = CODE_AND;
    d.illegal = 1'b0;
    case (op)
      3'b000, 3'b100: d.code = CODE_ADD;
      3'b001:         d.code = CODE_SUB;
      3'b011:         d.code = CODE_SLT;
      3'b010: begin
        case (funct)
          6'b100000: d.code = CODE_ADD;
          6'b100010: d.code = CODE_SUB;
          6'b100100: d.code = CODE_AND;
          6'b100101: d.code = CODE_OR;
          6'b101010: d.code = CODE_SLT;
          6'b011000: d.code = CODE_MUL;
`ifdef ALU_CTRL_DIV_EN
          6'b011010: d.code = CODE_DIV;
`endif
          default:   d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // DIV code only ever comes out of decode when the divider is enabled.
  function automatic logic [3:0] cnt_load(input dec_t d);
    logic [3:0] c;
    c = 4'd0;
    if (!d.illegal) begin
      case (d.code)
        CODE_MUL: c = MUL_CNT;
        CODE_DIV: c = DIV_CNT;
        default:  c = 4'd0;
      endcase
    end
    return c;
  endfunction

  assign dec    = decode(ALUOp_i, funct_i);
  assign accept = valid_i && !stall_o && !flush_i;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;

    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else if (accept) begin
      ctrl_d    = dec.code;
      illegal_d = dec.illegal;
      cnt_d     = cnt_load(dec);
      state_d   = (cnt_load(dec) != 4'd0) ? S_MULTI : S_EXEC;
    end else if (state_q == S_MULTI) begin
      // MULTI always holds cnt_q >= 1, so this never wraps.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = S_EXEC;
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      ctrl_q    <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALUCtrl_o = CTRL_W'(ctrl_q);
  assign illegal_o = illegal_q;
  assign valid_o   = (state_q != S_IDLE);
  assign stall_o   = (state_q == S_MULTI);
  assign done_o    = (state_q == S_EXEC);

endmodule
